// File: rtl/checker_pkg.sv
// Shared types and character constants for the checker stream arbiter.
package checker_pkg;

    typedef logic [7:0] char_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_REPORT   = 2'd3
    } state_t;

    localparam char_t CH_SOR        = 8'h5E;  // '^' start of record
    localparam char_t CH_EOR        = 8'h23;  // '#' end of record
    localparam char_t FILL_CHAR_DEF = 8'h20;  // space: idle/abort filler

endpackage

// File: rtl/checker_stream_arbiter_if.sv
// Requester-side bundle: two head-char streams in, per-requester result pulses out.
interface checker_stream_arbiter_if;
    logic [1:0]  req_valid;
    logic [15:0] req_char;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_format;
    logic [3:0]  rsp_error;

    // Requesters drive chars and receive ready/results.
    modport master (
        output req_valid, req_char,
        input  req_ready, rsp_valid, rsp_format, rsp_error
    );

    // The arbiter consumes chars and returns ready/results.
    modport slave (
        input  req_valid, req_char,
        output req_ready, rsp_valid, rsp_format, rsp_error
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer toggles only when update_i is strobed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    logic other;

    assign other = ~ptr_q;

    // Pointer register: favours requester 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (update_i) begin
            ptr_q <= ~ptr_q;
        end
    end

    // Favoured requester first, otherwise the other one.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_q]) begin
            gnt_o[ptr_q] = 1'b1;
        end else if (req_i[other]) begin
            gnt_o[other] = 1'b1;
        end
    end
endmodule

// File: rtl/checker_stream_arbiter.sv
// Shares one cpu_checker between two char-stream requesters, granting whole
// records round-robin and routing each checker result back to its sender.
module checker_stream_arbiter
    import checker_pkg::*;
#(
    parameter char_t FILL_CHAR  = FILL_CHAR_DEF,
    parameter int    MAX_LEN    = 64,
    parameter int    RESULT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    checker_stream_arbiter_if.slave  req_if,
    output char_t                    chk_char,
    input  logic [1:0]               chk_format_type,
    input  logic [3:0]               chk_error_code,
    output logic [1:0]               grant,
    output logic [7:0]               abort_cnt
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int LAT_W = $clog2(RESULT_LAT + 2);

    state_t           state_q;
    char_t            chk_char_q;
    logic [1:0]       grant_q;
    logic [1:0]       rsp_valid_q;
    logic [1:0]       rsp_format_q;
    logic [3:0]       rsp_error_q;
    logic [7:0]       abort_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [LAT_W-1:0] lat_cnt_q;

    char_t      head [2];
    logic [1:0] sor_req;
    logic [1:0] pick;
    logic [1:0] ready;
    logic       win_idx;
    logic       g_idx;
    logic       g_valid;
    char_t      g_char;
    logic       abort;
    logic       ptr_update;

    // Per-requester head char and start-of-record contention.
    for (genvar gi = 0; gi < 2; gi++) begin : g_head
        assign head[gi]    = req_if.req_char[8*gi +: 8];
        assign sor_req[gi] = req_if.req_valid[gi] && (head[gi] == CH_SOR);
    end

    assign win_idx = pick[1];
    assign g_idx   = grant_q[1];
    assign g_valid = req_if.req_valid[g_idx];
    assign g_char  = head[g_idx];

    // A record dies on a gap in the stream or on overlength without '#'.
    assign abort = (state_q == ST_STREAM) &&
                   (!g_valid || ((len_q == LEN_W'(MAX_LEN)) && (g_char != CH_EOR)));

    // Fairness advances only when a record finishes (reported) or aborts.
    assign ptr_update = abort || (state_q == ST_REPORT);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (sor_req),
        .update_i (ptr_update),
        .gnt_o    (pick)
    );

    // Ready: discard non-'^' garbage in IDLE, stream only from the owner.
    always_comb begin
        ready = 2'b00;
        case (state_q)
            ST_IDLE:   ready = (req_if.req_valid & ~sor_req) | pick;
            ST_STREAM: ready = req_if.req_valid & grant_q;
            default:   ready = 2'b00;
        endcase
    end

    // Record FSM with registered checker char, grant, counters and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            chk_char_q   <= FILL_CHAR;
            grant_q      <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_format_q <= 2'b00;
            rsp_error_q  <= 4'h0;
            abort_cnt_q  <= 8'h00;
            len_q        <= '0;
            lat_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    chk_char_q  <= FILL_CHAR;
                    rsp_valid_q <= 2'b00;
                    if (|pick) begin
                        chk_char_q <= head[win_idx];
                        grant_q    <= pick;
                        len_q      <= LEN_W'(1);
                        state_q    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        chk_char_q <= FILL_CHAR;
                        grant_q    <= 2'b00;
                        state_q    <= ST_IDLE;
                        if (abort_cnt_q != 8'hFF) begin
                            abort_cnt_q <= abort_cnt_q + 8'h01;
                        end
                    end else begin
                        chk_char_q <= g_char;
                        len_q      <= len_q + LEN_W'(1);
                        if (g_char == CH_EOR) begin
                            lat_cnt_q <= '0;
                            state_q   <= ST_WAIT_RES;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    chk_char_q <= FILL_CHAR;
                    if (lat_cnt_q == LAT_W'(RESULT_LAT)) begin
                        rsp_format_q <= chk_format_type;
                        rsp_error_q  <= chk_error_code;
                        rsp_valid_q  <= grant_q;
                        state_q      <= ST_REPORT;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                default: begin  // ST_REPORT: result pulse is on the outputs now
                    chk_char_q  <= FILL_CHAR;
                    rsp_valid_q <= 2'b00;
                    grant_q     <= 2'b00;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_if.req_ready  = ready;
    assign req_if.rsp_valid  = rsp_valid_q;
    assign req_if.rsp_format = rsp_format_q;
    assign req_if.rsp_error  = rsp_error_q;
    assign chk_char          = chk_char_q;
    assign grant             = grant_q;
    assign abort_cnt         = abort_cnt_q;
endmodule

// File: tb/tb_checker_stream_arbiter.sv
// Directed bench for checker_stream_arbiter with a one-cycle-latency checker stub.
module tb_checker_stream_arbiter;
    import checker_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    char_t      chk_char;
    logic [1:0] chk_format_type;
    logic [3:0] chk_error_code;
    logic [1:0] grant;
    logic [7:0] abort_cnt;
    logic [1:0] stub_fmt;
    logic [3:0] stub_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    checker_stream_arbiter_if sif ();

    checker_stream_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_if          (sif),
        .chk_char        (chk_char),
        .chk_format_type (chk_format_type),
        .chk_error_code  (chk_error_code),
        .grant           (grant),
        .abort_cnt       (abort_cnt)
    );

    // Checker stub: result valid the cycle after '#' appears on chk_char.
    always_ff @(posedge clk) begin
        chk_format_type <= (chk_char == CH_EOR) ? stub_fmt : 2'd0;
        chk_error_code  <= (chk_char == CH_EOR) ? stub_err : 4'd0;
    end

    typedef struct {
        logic [1:0] v;
        char_t      c0;
        char_t      c1;
        logic [1:0] fmt;
        logic [3:0] err;
        logic [1:0] exp_rdy;
        char_t      exp_chk;
        logic [1:0] exp_grant;
        logic [1:0] exp_rsp;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample combinational ready, then step past the edge.
    task automatic cyc(input logic [1:0] v, input char_t c0, input char_t c1, output logic [1:0] rdy);
        sif.req_valid = v;
        sif.req_char  = {c1, c0};
        #1;
        rdy = sif.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        sif.req_valid = 2'b00;
        sif.req_char  = 16'h2020;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rdy;
        string      s;
        int         fwd;

        tbl[0]  = '{2'b01, "a", 8'h20, 2'd1, 4'd0, 2'b01, 8'h20, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, "b", 8'h20, 2'd1, 4'd0, 2'b01, 8'h20, 2'b00, 2'b00};
        tbl[2]  = '{2'b01, "^", 8'h20, 2'd1, 4'd0, 2'b01, "^",   2'b01, 2'b00};
        tbl[3]  = '{2'b11, "X", "^",   2'd1, 4'd0, 2'b01, "X",   2'b01, 2'b00};
        tbl[4]  = '{2'b11, "#", "^",   2'd1, 4'd0, 2'b01, "#",   2'b01, 2'b00};
        tbl[5]  = '{2'b10, 8'h20, "^", 2'd1, 4'd0, 2'b00, 8'h20, 2'b01, 2'b00};
        tbl[6]  = '{2'b10, 8'h20, "^", 2'd1, 4'd0, 2'b00, 8'h20, 2'b01, 2'b01};
        tbl[7]  = '{2'b10, 8'h20, "^", 2'd2, 4'd5, 2'b00, 8'h20, 2'b00, 2'b00};
        tbl[8]  = '{2'b10, 8'h20, "^", 2'd2, 4'd5, 2'b10, "^",   2'b10, 2'b00};
        tbl[9]  = '{2'b10, 8'h20, "#", 2'd2, 4'd5, 2'b10, "#",   2'b10, 2'b00};
        tbl[10] = '{2'b00, 8'h20, 8'h20, 2'd2, 4'd5, 2'b00, 8'h20, 2'b10, 2'b00};
        tbl[11] = '{2'b00, 8'h20, 8'h20, 2'd2, 4'd5, 2'b00, 8'h20, 2'b10, 2'b10};
        tbl[12] = '{2'b00, 8'h20, 8'h20, 2'd2, 4'd5, 2'b00, 8'h20, 2'b00, 2'b00};

        stub_fmt = 2'd1;
        stub_err = 4'd0;
        do_reset();

        // Reset values.
        check("rst chk_char", chk_char, 8'h20);
        check("rst grant", grant, 2'b00);
        check("rst rsp_valid", sif.rsp_valid, 2'b00);
        check("rst rsp_format", sif.rsp_format, 2'b00);
        check("rst rsp_error", sif.rsp_error, 4'h0);
        check("rst abort_cnt", abort_cnt, 8'h00);
        check("rst req_ready", sif.req_ready, 2'b00);
        $display("reset: checked reset state");

        // 30-char record from requester 0, result latency check.
        s = "^32@00003004: $0040<=12345678#";
        for (int i = 0; i < 30; i++) begin
            cyc(2'b01, s[i], 8'h20, rdy);
            check("rec30 ready", rdy, 2'b01);
            check("rec30 chk_char", chk_char, s[i]);
            check("rec30 grant", grant, 2'b01);
        end
        cyc(2'b00, 8'h20, 8'h20, rdy);
        check("rec30 rsp early", sif.rsp_valid, 2'b00);
        check("rec30 fill", chk_char, 8'h20);
        cyc(2'b00, 8'h20, 8'h20, rdy);
        check("rec30 rsp_valid", sif.rsp_valid, 2'b01);
        check("rec30 rsp_format", sif.rsp_format, 2'd1);
        check("rec30 rsp_error", sif.rsp_error, 4'd0);
        cyc(2'b00, 8'h20, 8'h20, rdy);
        check("rec30 rsp pulse end", sif.rsp_valid, 2'b00);
        check("rec30 grant clear", grant, 2'b00);
        $display("record30: streamed %0d chars from requester 0", s.len());

        // Simultaneous '^': order 0, 1, 0.
        do_reset();
        cyc(2'b11, "^", "^", rdy);
        check("tie1 ready", rdy, 2'b01);
        check("tie1 grant", grant, 2'b01);
        cyc(2'b11, "#", "^", rdy);
        check("tie1 eor ready", rdy, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b10, 8'h20, "^", rdy);
            check("tie1 dead ready", rdy, 2'b00);
        end
        cyc(2'b11, "^", "^", rdy);
        check("tie2 ready", rdy, 2'b10);
        check("tie2 grant", grant, 2'b10);
        cyc(2'b11, "^", "#", rdy);
        check("tie2 eor ready", rdy, 2'b10);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, "^", 8'h20, rdy);
            check("tie2 dead ready", rdy, 2'b00);
        end
        cyc(2'b11, "^", "^", rdy);
        check("tie3 ready", rdy, 2'b01);
        cyc(2'b01, "#", 8'h20, rdy);
        for (int i = 0; i < 3; i++) cyc(2'b00, 8'h20, 8'h20, rdy);
        $display("tie: alternation 0,1,0 checked");

        // Table: leading garbage, then back-to-back short records.
        for (int i = 0; i < 13; i++) begin
            stub_fmt = tbl[i].fmt;
            stub_err = tbl[i].err;
            cyc(tbl[i].v, tbl[i].c0, tbl[i].c1, rdy);
            check($sformatf("vec%0d ready", i), rdy, tbl[i].exp_rdy);
            check($sformatf("vec%0d chk_char", i), chk_char, tbl[i].exp_chk);
            check($sformatf("vec%0d grant", i), grant, tbl[i].exp_grant);
            check($sformatf("vec%0d rsp_valid", i), sif.rsp_valid, tbl[i].exp_rsp);
            if (tbl[i].exp_rsp != 2'b00) begin
                check($sformatf("vec%0d rsp_format", i), sif.rsp_format, tbl[i].fmt);
                check($sformatf("vec%0d rsp_error", i), sif.rsp_error, tbl[i].err);
            end
            $display("vec %0d: valid=%b c0=%h c1=%h ready=%b chk=%h grant=%b rsp=%b",
                     i, tbl[i].v, tbl[i].c0, tbl[i].c1, rdy, chk_char, grant, sif.rsp_valid);
        end

        // Reset mid-record at char 15.
        s = "^ABCDEFGHIJKLMNOP";
        for (int i = 0; i < 14; i++) cyc(2'b01, s[i], 8'h20, rdy);
        check("midrst streaming", grant, 2'b01);
        reset = 1'b1;
        cyc(2'b01, s[14], 8'h20, rdy);
        reset = 1'b0;
        sif.req_valid = 2'b00;
        #1;
        check("midrst chk_char", chk_char, 8'h20);
        check("midrst grant", grant, 2'b00);
        check("midrst rsp_valid", sif.rsp_valid, 2'b00);
        check("midrst rsp_format", sif.rsp_format, 2'b00);
        check("midrst rsp_error", sif.rsp_error, 4'h0);
        check("midrst abort_cnt", abort_cnt, 8'h00);
        check("midrst ready", sif.req_ready, 2'b00);
        cyc(2'b11, "^", "^", rdy);
        check("midrst ptr0", rdy, 2'b01);
        $display("midreset: reset at char 15 checked");

        // Abort by dropping valid after 10 chars.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(2'b01, s[i], 8'h20, rdy);
            check("gap ready", rdy, 2'b01);
        end
        cyc(2'b00, 8'h20, 8'h20, rdy);
        check("gap fill", chk_char, 8'h20);
        check("gap abort_cnt", abort_cnt, 8'd1);
        check("gap grant", grant, 2'b00);
        check("gap rsp_valid", sif.rsp_valid, 2'b00);
        cyc(2'b11, "^", "^", rdy);
        check("gap ptr to 1", rdy, 2'b10);
        $display("gap abort: abort_cnt=%0d", abort_cnt);

        // Overlength: 70 chars without '#'.
        do_reset();
        fwd = 0;
        cyc(2'b01, "^", 8'h20, rdy);
        check("long sor ready", rdy, 2'b01);
        for (int i = 1; i < 70; i++) begin
            cyc(2'b01, "x", 8'h20, rdy);
            check("long ready", rdy, 2'b01);
            if (chk_char == "x") fwd++;
            if (i == 63) check("long char64", chk_char, "x");
            if (i == 64) begin
                check("long char65 fill", chk_char, 8'h20);
                check("long abort_cnt", abort_cnt, 8'd1);
            end
        end
        check("long forwarded", fwd, 63);
        check("long abort_cnt end", abort_cnt, 8'd1);
        $display("overlength: forwarded %0d body chars", fwd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
